// File: rtl/freq_ctrl_pkg.sv
// Shared types and constants for the frequency setpoint controller:
// the step-size ladder, the publish FSM states and the pulse directions.
package freq_ctrl_pkg;

  localparam int STEP_W = 16;

  // Base step sizes selected by step_idx 0..3
  localparam logic [STEP_W-1:0] STEP_LADDER [4] = '{16'd1, 16'd10, 16'd100, 16'd1000};

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/freq_accel_timer.sv
// Rotation acceleration detector: a restartable counter of clocks since the
// last accepted pulse (saturating at ACCEL_WIN) plus the direction of that
// pulse. Only built when FREQ_ACCEL_EN is defined.
`ifdef FREQ_ACCEL_EN
module freq_accel_timer
  import freq_ctrl_pkg::*;
#(
  parameter int ACCEL_WIN = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  dir_t dir,
  output logic accel
);

  localparam int            CW  = $clog2(ACCEL_WIN + 1);
  localparam logic [CW-1:0] WIN = CW'(ACCEL_WIN);

  logic [CW-1:0] count;
  dir_t          last_dir;

  // Restart the window on every accepted pulse, otherwise count up to the window limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= WIN;
      last_dir <= DIR_NONE;
    end else if (accept) begin
      count    <= '0;
      last_dir <= dir;
    end else if (count < WIN) begin
      count <= count + CW'(1);
    end
  end

  // A pulse is accelerated only when it continues the previous direction inside the window
  always_comb begin
    accel = (count < WIN) && (last_dir != DIR_NONE) && (dir == last_dir);
  end

endmodule
`endif

// File: rtl/freq_step_ctrl.sv
// Frequency setpoint controller: turns decoder up/down pulses into a
// saturated setpoint with a button-selected step size and publishes each
// new setpoint over a valid/ready handshake.
// Optional feature macro: FREQ_ACCEL_EN enables rotation acceleration.
module freq_step_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MIN_VAL    = 1,
  parameter int MAX_VAL    = 50000,
  parameter int INIT_VAL   = 1000,
  parameter int ACCEL_WIN  = 100000,
  parameter int ACCEL_MULT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  input  logic             step_btn,
  output logic [WIDTH-1:0] set_value,
  output logic [1:0]       step_idx,
  output logic             upd_valid,
  input  logic             upd_ready
);

  localparam logic [WIDTH:0]   MIN_EXT = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT_VAL);

  if (!(MIN_VAL <= INIT_VAL && INIT_VAL <= MAX_VAL &&
        longint'(MAX_VAL) < (longint'(1) << WIDTH) &&
        ACCEL_WIN >= 1 && ACCEL_MULT >= 1)) begin : g_bad_params
    $error("freq_step_ctrl: parameters must satisfy MIN_VAL <= INIT_VAL <= MAX_VAL < 2**WIDTH");
  end

  logic             step_btn_q;
  logic [WIDTH-1:0] value;
  logic             dirty;
  state_t           state;
  logic             pulse_acc;
  logic             capture;
  logic [WIDTH:0]   base_step;
  logic [WIDTH:0]   eff_step;
  logic [WIDTH:0]   val_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] next_value;

`ifdef FREQ_ACCEL_EN
  dir_t pulse_dir;
  logic accel;

  // Classify the current pulse for the acceleration detector
  always_comb begin
    pulse_dir = DIR_NONE;
    if (up && !down) pulse_dir = DIR_UP;
    else if (down && !up) pulse_dir = DIR_DOWN;
  end

  freq_accel_timer #(
    .ACCEL_WIN (ACCEL_WIN)
  ) u_accel (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (pulse_acc),
    .dir    (pulse_dir),
    .accel  (accel)
  );
`endif

  // Pick the step size and compute the clamped candidate value in WIDTH+1 bits
  always_comb begin
    pulse_acc = up ^ down;
    capture   = (state == IDLE) && dirty;
    base_step = (WIDTH+1)'(STEP_LADDER[step_idx]);
`ifdef FREQ_ACCEL_EN
    eff_step  = accel ? (WIDTH+1)'(int'(base_step) * ACCEL_MULT) : base_step;
`else
    eff_step  = base_step;
`endif
    val_ext    = {1'b0, value};
    sum        = val_ext + eff_step;
    next_value = value;
    if (up && !down) begin
      next_value = (sum > MAX_EXT) ? MAX_W : WIDTH'(sum);
    end else if (down && !up) begin
      next_value = (val_ext < eff_step + MIN_EXT) ? MIN_W : WIDTH'(val_ext - eff_step);
    end
  end

  // Step select: each rising edge of the button advances the ladder index, wrapping 3 to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_btn_q <= 1'b0;
      step_idx   <= 2'd0;
    end else begin
      step_btn_q <= step_btn;
      if (step_btn && !step_btn_q) step_idx <= step_idx + 2'd1;
    end
  end

  // Internal setpoint tracks every pulse; dirty marks a change not yet captured for publishing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT_W;
      dirty <= 1'b0;
    end else begin
      if (pulse_acc) value <= next_value;
      if (pulse_acc && (next_value != value)) dirty <= 1'b1;
      else if (capture) dirty <= 1'b0;
    end
  end

  // Publish FSM: capture the latest value when idle and hold it stable until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      set_value <= INIT_W;
      upd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dirty) begin
            set_value <= value;
            upd_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          upd_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Self-checking bench for freq_step_ctrl: a table of per-cycle vectors
// followed by hand-written multi-cycle sequences (saturation, step wrap,
// backpressure, asynchronous reset and, when FREQ_ACCEL_EN is defined,
// acceleration).
module tb_freq_step_ctrl;

  localparam int GAP = 80;

  logic        clk;
  logic        rst_n;
  logic        up;
  logic        down;
  logic        step_btn;
  logic        upd_ready;
  logic [15:0] set_value;
  logic [1:0]  step_idx;
  logic        upd_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic up;
    logic down;
    logic btn;
    logic ready;
    int   exp_sv;
    int   exp_idx;
    int   exp_valid;
  } vec_t;

  vec_t vecs [14];

  freq_step_ctrl #(
    .WIDTH      (16),
    .MIN_VAL    (1),
    .MAX_VAL    (50000),
    .INIT_VAL   (1000),
    .ACCEL_WIN  (64),
    .ACCEL_MULT (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up),
    .down      (down),
    .step_btn  (step_btn),
    .set_value (set_value),
    .step_idx  (step_idx),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    up        = v.up;
    down      = v.down;
    step_btn  = v.btn;
    upd_ready = v.ready;
    tick();
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    up        = 1'b0;
    down      = 1'b0;
    step_btn  = 1'b0;
    upd_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pressBtn(input string name, input int exp_idx);
    step_btn = 1'b1;
    tick();
    checkOutput(name, int'(step_idx), exp_idx);
    step_btn = 1'b0;
    tick();
  endtask

  // One pulse, then check the offer exactly two clocks later and idle out the gap
  task automatic pulseAndCheck(input string name, input logic u, input logic d,
                               input int exp_sv, input int exp_upd, input int gap);
    up   = u;
    down = d;
    tick();
    up   = 1'b0;
    down = 1'b0;
    checkOutput({name, " valid@N+1"}, int'(upd_valid), 0);
    tick();
    checkOutput({name, " valid@N+2"}, int'(upd_valid), exp_upd);
    checkOutput({name, " set_value"}, int'(set_value), exp_sv);
    for (int i = 0; i < gap; i++) tick();
  endtask

  initial begin
    int exp_v;

    // Per-cycle vectors: inputs for one clock, expected outputs after that edge
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1000, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1000, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1001, 0, 1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1001, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1001, 1, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1001, 1, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1001, 1, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1001, 1, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1,  991, 1, 1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0,  991, 1, 1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0,  991, 1, 1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1,  991, 1, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1001, 1, 1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1001, 1, 0};

    doReset();

    // Quiet period after reset
    checkOutput("reset set_value", int'(set_value), 1000);
    checkOutput("reset step_idx", int'(step_idx), 0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("reset quiet valid", int'(upd_valid), 0);
      tick();
    end

    // Table-driven section
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d set_value", i), int'(set_value), vecs[i].exp_sv);
      checkOutput($sformatf("vec%0d step_idx", i), int'(step_idx), vecs[i].exp_idx);
      checkOutput($sformatf("vec%0d upd_valid", i), int'(upd_valid), vecs[i].exp_valid);
    end
    up = 1'b0; down = 1'b0; step_btn = 1'b0; upd_ready = 1'b1;
    repeat (GAP) tick();

    // Step 100 down to the lower limit, then a pulse that cannot move the value
    doReset();
    pressBtn("btn press 1", 1);
    pressBtn("btn press 2", 2);
    for (int k = 1; k <= 9; k++) begin
      pulseAndCheck($sformatf("down100 #%0d", k), 1'b0, 1'b1, 1000 - 100 * k, 1, GAP);
    end
    pulseAndCheck("down clamp min", 1'b0, 1'b1, 1, 1, GAP);
    pulseAndCheck("down at min", 1'b0, 1'b1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("no offer at min", int'(upd_valid), 0);
      tick();
    end
    repeat (GAP) tick();

    // Step 1000 up to the upper limit, then wrap the step index back to 0
    pressBtn("btn press 3", 3);
    for (int k = 1; k <= 50; k++) begin
      exp_v = 1 + 1000 * k;
      if (exp_v > 50000) exp_v = 50000;
      pulseAndCheck($sformatf("up1000 #%0d", k), 1'b1, 1'b0, exp_v, 1, GAP);
    end
    pulseAndCheck("up at max", 1'b1, 1'b0, 50000, 0, GAP);
    pressBtn("btn wrap", 0);

    // Backpressure: offer of 1001 held while four more pulses arrive
    doReset();
    upd_ready = 1'b0;
    up = 1'b1;
    tick();
    up = 1'b0;
    tick();
    checkOutput("hold first valid", int'(upd_valid), 1);
    checkOutput("hold first value", int'(set_value), 1001);
    for (int p = 1; p <= 4; p++) begin
      repeat (GAP) tick();
      up = 1'b1;
      tick();
      up = 1'b0;
      tick();
      checkOutput($sformatf("hold valid p%0d", p), int'(upd_valid), 1);
      checkOutput($sformatf("hold value p%0d", p), int'(set_value), 1001);
    end
    upd_ready = 1'b1;
    tick();
    checkOutput("hold handshake valid", int'(upd_valid), 0);
    upd_ready = 1'b0;
    tick();
    checkOutput("hold republish valid", int'(upd_valid), 1);
    checkOutput("hold republish value", int'(set_value), 1005);

    // Asynchronous reset in the middle of an offer
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", int'(upd_valid), 0);
    checkOutput("async reset value", int'(set_value), 1000);
    checkOutput("async reset step_idx", int'(step_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    upd_ready = 1'b1;
    tick();
    checkOutput("after reset valid", int'(upd_valid), 0);

`ifdef FREQ_ACCEL_EN
    // Acceleration: close same-direction pulses use 10x the base step, reversal uses the base
    doReset();
    pressBtn("accel btn", 1);
    pulseAndCheck("accel first", 1'b1, 1'b0, 1010, 1, 8);
    pulseAndCheck("accel second", 1'b1, 1'b0, 1110, 1, 8);
    pulseAndCheck("accel third", 1'b1, 1'b0, 1210, 1, 8);
    pulseAndCheck("accel reversal", 1'b0, 1'b1, 1200, 1, GAP);
    pulseAndCheck("accel expired", 1'b0, 1'b1, 1190, 1, GAP);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
